// File: rtl/mod_updown_counter_pkg.sv
// Constants shared by the counter family of display blocks.
// The direction encoding is the only thing that has to match across them.
package mod_updown_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/rate_divider.sv
// Programmable rate divider: tick is high on every (div_val+1)-th enabled clock.
// A new div_val is only picked up at a reload, never while a period is in progress.
module rate_divider #(
    parameter int DIV_W = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_val,
    input  logic             sync_reload,
    output logic             tick
);

    logic [DIV_W-1:0] pre_d;
    logic [DIV_W-1:0] pre_q;

    // pre resets to zero, so the first enabled edge after reset is already a tick.
    assign tick = enable && (pre_q == '0);

    always_comb begin
        // NOTE: default assignment first, so no path through the block leaves pre_d unassigned (no latch).
        pre_d = pre_q;
        if (sync_reload || tick) begin
            pre_d = div_val;
        end else if (enable) begin
            pre_d = pre_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Up/down modulo counter over 0..modulus, advanced by a programmable rate divider.
// tc is a one-cycle pulse that lines up with the wrapped value of q.
module mod_updown_counter
    import mod_updown_counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] modulus,
    input  logic [DIV_W-1:0] div_val,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    logic             tick;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;
    logic             tc_d;
    logic             tc_q;

    // A load also restarts the divider phase.
    rate_divider #(
        .DIV_W (DIV_W)
    ) u_rate_divider (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .div_val     (div_val),
        .sync_reload (load),
        .tick        (tick)
    );

    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (load) begin
            q_d = load_val;
        end else if (tick) begin
            case (up)
                DIR_UP: begin
                    // >= rather than == so an out-of-range q wraps to 0 on the next up tick.
                    if (q_q >= modulus) begin
                        q_d  = '0;
                        tc_d = 1'b1;
                    end else begin
                        q_d = q_q + 1'b1;
                    end
                end
                DIR_DOWN: begin
                    if (q_q == '0) begin
                        q_d  = modulus;
                        tc_d = 1'b1;
                    end else begin
                        q_d = q_q - 1'b1;
                    end
                end
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign q  = q_q;
    assign tc = tc_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench for mod_updown_counter (WIDTH=8, DIV_W=4): directed scenarios
// plus randomized traffic, all compared against a behavioural model of the counter.
module tb_mod_updown_counter;

    localparam int WIDTH = 8;
    localparam int DIV_W = 4;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] modulus;
    logic [DIV_W-1:0] div_val;
    logic [WIDTH-1:0] q;
    logic             tc;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: m_credit = enabled clocks still needed until the next tick fires.
    int m_q;
    bit m_tc;
    int m_credit;

    mod_updown_counter #(
        .WIDTH (WIDTH),
        .DIV_W (DIV_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .modulus  (modulus),
        .div_val  (div_val),
        .q        (q),
        .tc       (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_q      = 0;
        m_tc     = 1'b0;
        m_credit = 1;
    endtask

    // Applies the counter rules to the inputs present at this rising edge.
    task automatic model_edge();
        int mod;
        mod = int'(modulus);
        if (load) begin
            m_q      = int'(load_val);
            m_tc     = 1'b0;
            m_credit = int'(div_val) + 1;
        end else if (enable && m_credit == 1) begin
            m_credit = int'(div_val) + 1;
            if (up) begin
                m_tc = (m_q >= mod);
                m_q  = (m_q >= mod) ? 0 : m_q + 1;
            end else begin
                m_tc = (m_q == 0);
                m_q  = (m_q == 0) ? mod : m_q - 1;
            end
        end else begin
            m_tc = 1'b0;
            if (enable) m_credit = m_credit - 1;
        end
    endtask

    // One clock: model follows the rising edge, outputs are then sampled at the falling edge.
    task automatic clk_cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #3;
        if (q !== 8'h00 || tc !== 1'b0) begin
            $display("FAIL reset_async: q=%0h tc=%0b expected q=0 tc=0", q, tc);
            failures++;
        end
        checks++;
        repeat (2) @(negedge clk);
        if (q !== 8'h00 || tc !== 1'b0) begin
            $display("FAIL reset_held: q=%0h tc=%0b expected q=0 tc=0", q, tc);
            failures++;
        end
        checks++;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_count_up();
        int exp_seq [11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
        enable = 1'b1; up = 1'b1; div_val = '0; modulus = 8'd9;
        for (int i = 0; i < 11; i++) begin
            clk_cycle();
            if (q !== 8'(exp_seq[i]) || tc !== (i == 9)) begin
                $display("FAIL count_up step %0d: q=%0d tc=%0b expected q=%0d tc=%0b",
                         i, q, tc, exp_seq[i], (i == 9));
                failures++;
            end
            checks++;
            if (q !== 8'(m_q) || tc !== m_tc) begin
                $display("FAIL count_up_model step %0d: q=%0d tc=%0b model q=%0d tc=%0b",
                         i, q, tc, m_q, m_tc);
                failures++;
            end
            checks++;
        end
    endtask

    task automatic test_divider();
        div_val = 4'd3; modulus = 8'd255; up = 1'b1; enable = 1'b1;
        for (int i = 0; i < 29; i++) begin
            enable = !(i >= 12 && i < 17);
            clk_cycle();
            if (q !== 8'(m_q) || tc !== m_tc) begin
                $display("FAIL divider step %0d: q=%0d tc=%0b model q=%0d tc=%0b",
                         i, q, tc, m_q, m_tc);
                failures++;
            end
            checks++;
            if (i >= 12 && i < 17 && q !== 8'd4) begin
                $display("FAIL divider_hold step %0d: q=%0d expected 4", i, q);
                failures++;
            end
            if (i >= 12 && i < 17) checks++;
        end
        if (q !== 8'd7) begin
            $display("FAIL divider_total: q=%0d expected 7", q);
            failures++;
        end
        checks++;
        enable = 1'b1;
    endtask

    task automatic test_count_down();
        int exp_seq [7] = '{5, 4, 3, 2, 1, 0, 5};
        div_val = '0; up = 1'b0; modulus = 8'd5; enable = 1'b1;
        load = 1'b1; load_val = 8'd0;
        clk_cycle();
        load = 1'b0;
        for (int i = 0; i < 7; i++) begin
            clk_cycle();
            if (q !== 8'(exp_seq[i]) || tc !== (i == 0 || i == 6) ||
                q !== 8'(m_q) || tc !== m_tc) begin
                $display("FAIL count_down step %0d: q=%0d tc=%0b expected q=%0d tc=%0b",
                         i, q, tc, exp_seq[i], (i == 0 || i == 6));
                failures++;
            end
            checks++;
        end
        modulus = 8'd255; load = 1'b1; load_val = 8'd0;
        clk_cycle();
        load = 1'b0;
        clk_cycle();
        if (q !== 8'd255 || tc !== 1'b1) begin
            $display("FAIL down_wrap_255: q=%0d tc=%0b expected q=255 tc=1", q, tc);
            failures++;
        end
        checks++;
        up = 1'b1;
        clk_cycle();
        if (q !== 8'd0 || tc !== 1'b1) begin
            $display("FAIL up_wrap_255: q=%0d tc=%0b expected q=0 tc=1", q, tc);
            failures++;
        end
        checks++;
    endtask

    task automatic test_load();
        enable = 1'b0; div_val = '0; load = 1'b1; load_val = 8'hAB;
        clk_cycle();
        if (q !== 8'hAB || tc !== 1'b0) begin
            $display("FAIL load_disabled: q=%0h tc=%0b expected q=ab tc=0", q, tc);
            failures++;
        end
        checks++;
        load = 1'b0; modulus = 8'd9; up = 1'b1; enable = 1'b1;
        clk_cycle();
        if (q !== 8'd0 || tc !== 1'b1) begin
            $display("FAIL load_over_modulus: q=%0d tc=%0b expected q=0 tc=1", q, tc);
            failures++;
        end
        checks++;
        enable = 1'b0;
        clk_cycle();
        if (q !== 8'd0 || tc !== 1'b0 || q !== 8'(m_q) || tc !== m_tc) begin
            $display("FAIL idle_hold: q=%0d tc=%0b expected q=0 tc=0", q, tc);
            failures++;
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] lv;
        enable = 1'b1; div_val = '0; up = 1'b1; modulus = 8'd9;
        load = 1'b1; load_val = 8'd9;
        clk_cycle();
        // The divider is at zero and q is at modulus, so this edge would otherwise wrap.
        lv = 8'($urandom_range(0, 255));
        load_val = lv;
        clk_cycle();
        if (q !== lv || tc !== 1'b0) begin
            $display("FAIL load_vs_tick: q=%0h tc=%0b expected q=%0h tc=0", q, tc, lv);
            failures++;
        end
        checks++;
        load = 1'b0;
        clk_cycle();
        if (q !== 8'(m_q) || tc !== m_tc) begin
            $display("FAIL after_load_tick: q=%0d tc=%0b model q=%0d tc=%0b", q, tc, m_q, m_tc);
            failures++;
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        load = 1'b1; load_val = 8'h37; enable = 1'b0;
        clk_cycle();
        load = 1'b0; div_val = 4'd3;
        if (q !== 8'h37) begin
            $display("FAIL preload_37: q=%0h expected 37", q);
            failures++;
        end
        checks++;
        #2 reset = 1'b1;
        #1;
        if (q !== 8'h00 || tc !== 1'b0) begin
            $display("FAIL reset_mid: q=%0h tc=%0b expected q=0 tc=0", q, tc);
            failures++;
        end
        checks++;
        model_reset();
        reset = 1'b0; enable = 1'b1; up = 1'b1; modulus = 8'd255;
        clk_cycle();
        if (q !== 8'd1 || tc !== 1'b0 || q !== 8'(m_q)) begin
            $display("FAIL first_after_reset: q=%0d tc=%0b expected q=1 tc=0", q, tc);
            failures++;
        end
        checks++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            load     = ($urandom_range(0, 19) == 0);
            load_val = 8'($urandom_range(0, 255));
            enable   = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 7) == 0) up = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0:       modulus = 8'd0;
                    1:       modulus = 8'd255;
                    default: modulus = 8'($urandom_range(1, 20));
                endcase
            end
            if ($urandom_range(0, 15) == 0) div_val = 4'($urandom_range(0, 3));
            clk_cycle();
            if (q !== 8'(m_q) || tc !== m_tc) begin
                $display("FAIL random step %0d: q=%0d tc=%0b model q=%0d tc=%0b",
                         i, q, tc, m_q, m_tc);
                failures++;
            end
            checks++;
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; up = 1'b1; load = 1'b0;
        load_val = '0; modulus = 8'd9; div_val = '0;
        model_reset();
        test_reset();
        test_count_up();
        test_divider();
        test_count_down();
        test_load();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
